// File: rtl/fdivsqrt_pkg.sv
// Shared types for the divide/sqrt issue block.
package fdivsqrt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        DRAIN
    } fdivsqrt_issue_state_t;

endpackage

// File: rtl/fdivsqrt_issue_if.sv
// Request, divide-unit and response signals of the divide/sqrt issue block.
interface fdivsqrt_issue_if #(
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [TAG_W-1:0] req_tag;
    logic             req_sqrt;
    logic             flush;
    logic             div_start;
    logic             div_sqrt;
    logic             div_busy;
    logic             div_done;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_timeout;
    logic             busy;

    // master: the surroundings of the block (pipeline, divide unit, writeback)
    modport master (
        output req_valid, req_tag, req_sqrt, flush, div_busy, div_done, rsp_ready,
        input  req_ready, div_start, div_sqrt, rsp_valid, rsp_tag, rsp_timeout, busy
    );

    modport slave (
        input  req_valid, req_tag, req_sqrt, flush, div_busy, div_done, rsp_ready,
        output req_ready, div_start, div_sqrt, rsp_valid, rsp_tag, rsp_timeout, busy
    );

endinterface

// File: rtl/fdivsqrt_wdog.sv
// Saturating watchdog: counts enabled cycles, flags the TMO_CYC-th one.
module fdivsqrt_wdog #(
    parameter int TMO_CYC = 128
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int               CNT_W = $clog2(TMO_CYC);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TMO_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = enable && (cnt_q == LAST);

endmodule

// File: rtl/flopenr.sv
// Enabled register with synchronous active-low reset.
module flopenr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: reset is sampled on the clock edge, so it lives inside the clocked block
    // and never in the sensitivity list; non-blocking assignment keeps flop updates
    // order-independent.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fdivsqrt_issue.sv
// Issues one divide/sqrt request at a time, waits for completion or a
// watchdog timeout, and hands the tagged completion downstream.
module fdivsqrt_issue
    import fdivsqrt_pkg::*;
#(
    parameter int TAG_W   = 5,
    parameter int TMO_CYC = 128
) (
    input logic             clk,
    input logic             reset,
    fdivsqrt_issue_if.slave bus
);

    fdivsqrt_issue_state_t state_q;
    fdivsqrt_issue_state_t state_d;
    logic                  rsp_timeout_q;
    logic                  rsp_timeout_d;
    logic                  accept;
    logic                  wd_expire;
    logic [TAG_W:0]        cap_q;

    assign bus.req_ready   = (state_q == IDLE) && !bus.flush;
    assign accept          = bus.req_valid && bus.req_ready;
    assign bus.div_start   = (state_q == ISSUE) && !bus.flush;
    assign bus.rsp_valid   = (state_q == RESP) && !bus.flush;
    assign bus.busy        = (state_q != IDLE);
    assign bus.rsp_tag     = cap_q[TAG_W:1];
    assign bus.div_sqrt    = cap_q[0];
    assign bus.rsp_timeout = rsp_timeout_q;

    flopenr #(.WIDTH(TAG_W + 1)) u_cap (
        .clk   (clk),
        .reset (reset),
        .en    (accept),
        .d     ({bus.req_tag, bus.req_sqrt}),
        .q     (cap_q)
    );

    fdivsqrt_wdog #(.TMO_CYC(TMO_CYC)) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q != WAIT),
        .enable (state_q == WAIT),
        .expire (wd_expire)
    );

    always_comb begin
        state_d       = state_q;
        rsp_timeout_d = rsp_timeout_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = ISSUE;
            end
            ISSUE: begin
                // A unit that already took the start must be drained before reuse.
                if (bus.flush)         state_d = bus.div_busy ? DRAIN : IDLE;
                else if (bus.div_busy) state_d = WAIT;
            end
            WAIT: begin
                if (bus.flush) begin
                    state_d = DRAIN;
                end else if (bus.div_done) begin
                    state_d       = RESP;
                    rsp_timeout_d = 1'b0;
                end else if (wd_expire) begin
                    state_d       = RESP;
                    rsp_timeout_d = 1'b1;
                end
            end
            RESP: begin
                if (bus.flush || bus.rsp_ready) state_d = IDLE;
            end
            DRAIN: begin
                if (bus.div_done || !bus.div_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

endmodule

// File: tb/tb_fdivsqrt_issue.sv
// Directed bench: instance a uses the default watchdog, instance b TMO_CYC=8.
module tb_fdivsqrt_issue;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [4:0] req_tag;
    logic       req_sqrt;
    logic       flush;
    logic       div_busy;
    logic       div_done;
    logic       rsp_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fdivsqrt_issue_if #(.TAG_W(5)) if_a ();
    fdivsqrt_issue_if #(.TAG_W(5)) if_b ();

    assign if_a.req_valid = req_valid;
    assign if_a.req_tag   = req_tag;
    assign if_a.req_sqrt  = req_sqrt;
    assign if_a.flush     = flush;
    assign if_a.div_busy  = div_busy;
    assign if_a.div_done  = div_done;
    assign if_a.rsp_ready = rsp_ready;
    assign if_b.req_valid = req_valid;
    assign if_b.req_tag   = req_tag;
    assign if_b.req_sqrt  = req_sqrt;
    assign if_b.flush     = flush;
    assign if_b.div_busy  = div_busy;
    assign if_b.div_done  = div_done;
    assign if_b.rsp_ready = rsp_ready;

    fdivsqrt_issue #(.TAG_W(5), .TMO_CYC(128)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a)
    );

    fdivsqrt_issue #(.TAG_W(5), .TMO_CYC(8)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req_valid = 1'b0;
        req_tag   = '0;
        req_sqrt  = 1'b0;
        flush     = 1'b0;
        div_busy  = 1'b0;
        div_done  = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Accept one request; returns at the negedge where the block sits in ISSUE.
    task automatic send_req(input logic [4:0] tag, input logic sqrt);
        req_valid = 1'b1;
        req_tag   = tag;
        req_sqrt  = sqrt;
        @(negedge clk);
        req_valid = 1'b0;
        req_tag   = 5'h1F;
        req_sqrt  = ~sqrt;
    endtask

    // Request plus immediate unit acceptance; returns in WAIT cycle 1.
    task automatic go_wait(input logic [4:0] tag, input logic sqrt);
        send_req(tag, sqrt);
        div_busy = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int n;
        int xfer;
        int unstable;

        // reset values
        do_reset();
        reset = 1'b0;
        #1;
        check("rst_req_ready", if_a.req_ready, 1);
        check("rst_div_start", if_a.div_start, 0);
        check("rst_rsp_valid", if_a.rsp_valid, 0);
        check("rst_busy", if_a.busy, 0);
        check("rst_rsp_tag", if_a.rsp_tag, 0);
        check("rst_timeout", if_a.rsp_timeout, 0);
        check("rst_b_busy", if_b.busy, 0);
        reset = 1'b1;

        // flush in IDLE blocks acceptance
        @(negedge clk);
        req_valid = 1'b1;
        req_tag   = 5'h11;
        flush     = 1'b1;
        #1 check("idle_flush_ready", if_a.req_ready, 0);
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;
        #1 check("idle_flush_noacc", if_a.busy, 0);

        // divide, completion 20 cycles into WAIT
        do_reset();
        req_valid = 1'b1;
        req_tag   = 5'h0A;
        req_sqrt  = 1'b0;
        #1 check("a_req_ready", if_a.req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        req_tag   = 5'h1F;
        req_sqrt  = 1'b1;
        div_busy  = 1'b1;
        #1;
        check("a_div_start", if_a.div_start, 1);
        check("a_busy", if_a.busy, 1);
        check("a_cap_tag", if_a.rsp_tag, 5'h0A);
        check("a_cap_sqrt", if_a.div_sqrt, 0);
        @(negedge clk);
        #1 check("a_wait_nostart", if_a.div_start, 0);
        n = 0;
        repeat (19) begin
            if (if_a.rsp_valid) n++;
            @(negedge clk);
            #1;
        end
        check("a_wait_norsp", n, 0);
        div_done = 1'b1;
        @(negedge clk);
        div_done  = 1'b0;
        div_busy  = 1'b0;
        req_valid = 1'b1;
        #1;
        check("a_rsp_valid", if_a.rsp_valid, 1);
        check("a_rsp_tag", if_a.rsp_tag, 5'h0A);
        check("a_rsp_timeout", if_a.rsp_timeout, 0);
        check("a_resp_noready", if_a.req_ready, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        #1;
        check("a_done_idle", if_a.busy, 0);
        check("a_done_norsp", if_a.rsp_valid, 0);

        // stalled unit: start held for 3 idle cycles plus the accepting one
        do_reset();
        send_req(5'h15, 1'b1);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            div_busy = (i >= 3);
            #1;
            if (if_a.div_start) n++;
            @(negedge clk);
        end
        check("stall_start_cnt", n, 4);
        #1;
        check("stall_in_wait", if_a.busy, 1);
        check("stall_sqrt", if_a.div_sqrt, 1);
        check("stall_tag", if_a.rsp_tag, 5'h15);

        // watchdog expiry, TMO_CYC=8
        do_reset();
        go_wait(5'h03, 1'b0);
        n = 0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            if (if_b.rsp_valid) n++;
            @(negedge clk);
        end
        #1;
        check("tmo_early_rsp", n, 0);
        check("tmo_rsp_valid", if_b.rsp_valid, 1);
        check("tmo_timeout", if_b.rsp_timeout, 1);
        check("tmo_tag", if_b.rsp_tag, 5'h03);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1 check("tmo_idle", if_b.busy, 0);

        // div_done in the expiry cycle wins
        go_wait(5'h04, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            div_done = (k == 8);
            @(negedge clk);
        end
        div_done = 1'b0;
        #1;
        check("tmo_tie_valid", if_b.rsp_valid, 1);
        check("tmo_tie_timeout", if_b.rsp_timeout, 0);

        // flush in WAIT cycle 3, done 5 cycles later
        do_reset();
        go_wait(5'h09, 1'b0);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("drain_busy", if_a.busy, 1);
        check("drain_noready", if_a.req_ready, 0);
        n = 0;
        for (int k = 1; k <= 5; k++) begin
            div_done = (k == 5);
            #1;
            if (if_a.rsp_valid) n++;
            @(negedge clk);
        end
        div_done = 1'b0;
        div_busy = 1'b0;
        #1;
        check("drain_norsp", n + int'(if_a.rsp_valid), 0);
        check("drain_ready", if_a.req_ready, 1);
        check("drain_idle", if_a.busy, 0);

        // flush in ISSUE: unit idle -> IDLE, unit busy -> DRAIN
        do_reset();
        send_req(5'h02, 1'b0);
        flush = 1'b1;
        #1 check("iss_flush_nostart", if_a.div_start, 0);
        @(negedge clk);
        flush = 1'b0;
        #1 check("iss_flush_idle", if_a.busy, 0);
        send_req(5'h06, 1'b0);
        div_busy = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        div_busy = 1'b0;
        @(negedge clk);
        #1 check("iss_flush_drain_exit", if_a.busy, 0);

        // back-pressure for 10 cycles, then one transfer
        do_reset();
        go_wait(5'h1C, 1'b1);
        div_done = 1'b1;
        @(negedge clk);
        div_done = 1'b0;
        div_busy = 1'b0;
        xfer     = 0;
        unstable = 0;
        for (int i = 0; i < 14; i++) begin
            rsp_ready = (i >= 10);
            #1;
            if (if_a.rsp_valid && rsp_ready) xfer++;
            if (i < 10 && !(if_a.rsp_valid && if_a.rsp_tag == 5'h1C && !if_a.rsp_timeout))
                unstable++;
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        check("bp_stable", unstable, 0);
        check("bp_xfer", xfer, 1);

        // flush together with rsp_ready discards the response
        go_wait(5'h07, 1'b0);
        div_done = 1'b1;
        @(negedge clk);
        div_done  = 1'b0;
        div_busy  = 1'b0;
        rsp_ready = 1'b1;
        flush     = 1'b1;
        #1 check("rflush_novalid", if_a.rsp_valid, 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("rflush_idle", if_a.busy, 0);
        check("rflush_norsp", if_a.rsp_valid, 0);
        rsp_ready = 1'b0;

        // reset mid-WAIT, late div_done ignored
        do_reset();
        go_wait(5'h13, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("mrst_busy", if_a.busy, 0);
        check("mrst_rsp_valid", if_a.rsp_valid, 0);
        check("mrst_tag", if_a.rsp_tag, 0);
        check("mrst_sqrt", if_a.div_sqrt, 0);
        reset    = 1'b1;
        div_done = 1'b1;
        @(negedge clk);
        div_done = 1'b0;
        div_busy = 1'b0;
        n = 0;
        repeat (3) begin
            #1;
            if (if_a.rsp_valid || if_a.busy) n++;
            @(negedge clk);
        end
        check("mrst_late_done", n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
